// File: rtl/lsp_dequant_2400_pkg.sv
// codec2_lsp_pkg: shared constants for the 2400 b/s LSP dequantiser.
// Contents:
// - N, NUM_LSP, IDX_W : data width, LSPs per frame, packed index word width
// - CB_BITS, CB_OFF   : bits per codebook and each index's bit offset in the word
// - C_PI4000          : pi/4000 in Q0.32, the Hz -> radian scale factor
// - state_t           : dequantiser FSM states
// - lsp_index()       : extracts index k from the packed word, zero-extended to 4 bits
package codec2_lsp_pkg;

    localparam int unsigned N       = 32;
    localparam int unsigned NUM_LSP = 10;
    localparam int unsigned IDX_W   = 36;

    localparam int unsigned CB_BITS [NUM_LSP] = '{4, 4, 4, 4, 4, 4, 4, 3, 3, 2};
    localparam int unsigned CB_OFF  [NUM_LSP] = '{0, 4, 8, 12, 16, 20, 24, 28, 31, 34};

    localparam logic [31:0] C_PI4000 = 32'd3373259;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_MUL   = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // The mask drops the bits of the following fields, which also
    // zero-extends the 3- and 2-bit indices.
    function automatic logic [3:0] lsp_index(input logic [IDX_W-1:0] w,
                                             input logic [3:0]       k);
        lsp_index = '0;
        for (int unsigned i = 0; i < NUM_LSP; i++) begin
            if (k == 4'(i)) begin
                lsp_index = 4'((w >> CB_OFF[i]) &
                               ((IDX_W'(1) << CB_BITS[i]) - IDX_W'(1)));
            end
        end
    endfunction

endpackage

// File: rtl/lsp_dequant_2400_cb_rom.sv
// lsp_cb_rom: the ten scalar LSP codebooks of the 2400 b/s mode.
// Purely combinational. It sits beside lsp_dequant_2400 in the decoder top and
// answers its cb_sel/cb_addr request in the same cycle.
// Ports:
// - cb_sel  in  4   codebook 0..9
// - cb_addr in  4   entry address. Only the low 3/2 bits are used for the
//                   8- and 4-entry codebooks.
// - cb_data out 32  entry in Hz, Q15.16. Returns 0 for an unused codebook select.
module lsp_cb_rom
    import codec2_lsp_pkg::*;
(
    input  logic [3:0]   cb_sel,
    input  logic [3:0]   cb_addr,
    output logic [N-1:0] cb_data
);

    // Entries are whole Hz. They are scaled to Q15.16 on the way out.
    localparam int unsigned ROM_cb1 [16] = '{ 225,  250,  275,  300,  325,  350,  375,  400,
                                              425,  450,  475,  500,  525,  550,  575,  600};
    localparam int unsigned ROM_cb2 [16] = '{ 325,  350,  375,  400,  425,  450,  475,  500,
                                              525,  550,  575,  600,  625,  650,  675,  700};
    localparam int unsigned ROM_cb3 [16] = '{ 500,  550,  600,  650,  700,  750,  800,  850,
                                              900,  950, 1000, 1050, 1100, 1150, 1200, 1250};
    localparam int unsigned ROM_cb4 [16] = '{ 950, 1050, 1150, 1250, 1350, 1450, 1550, 1650,
                                             1750, 1850, 1950, 2050, 2150, 2250, 2350, 2450};
    localparam int unsigned ROM_cb5 [16] = '{1150, 1250, 1350, 1450, 1550, 1650, 1750, 1850,
                                             1950, 2050, 2150, 2250, 2350, 2450, 2550, 2650};
    localparam int unsigned ROM_cb6 [16] = '{1300, 1400, 1500, 1600, 1700, 1800, 1900, 2000,
                                             2100, 2200, 2300, 2400, 2500, 2600, 2700, 2800};
    localparam int unsigned ROM_cb7 [16] = '{1500, 1600, 1700, 1800, 1900, 2000, 2100, 2200,
                                             2300, 2400, 2500, 2600, 2700, 2800, 2900, 3000};
    localparam int unsigned ROM_cb8 [8]  = '{2300, 2400, 2500, 2600, 2700, 2800, 2900, 3000};
    localparam int unsigned ROM_cb9 [8]  = '{2500, 2600, 2700, 2800, 2900, 3000, 3100, 3200};
    localparam int unsigned ROM_cb10 [4] = '{2900, 3100, 3300, 3500};

    logic [31:0] hz;

    always_comb begin
        hz = '0;
        case (cb_sel)
            4'd0:    hz = ROM_cb1[cb_addr];
            4'd1:    hz = ROM_cb2[cb_addr];
            4'd2:    hz = ROM_cb3[cb_addr];
            4'd3:    hz = ROM_cb4[cb_addr];
            4'd4:    hz = ROM_cb5[cb_addr];
            4'd5:    hz = ROM_cb6[cb_addr];
            4'd6:    hz = ROM_cb7[cb_addr];
            4'd7:    hz = ROM_cb8[cb_addr[2:0]];
            4'd8:    hz = ROM_cb9[cb_addr[2:0]];
            4'd9:    hz = ROM_cb10[cb_addr[1:0]];
            default: hz = '0;
        endcase
    end

    assign cb_data = hz << 16;

endmodule

// File: rtl/lsp_dequant_2400.sv
// lsp_dequant_2400: unpacks the 36-bit LSP index word and reads one
// codebook entry per LSP. Each entry is converted from Hz to radians
// (x pi/4000). The 10 LSPs go out in order on a valid/ready stream.
// Ports:
// - clk, rst     clock and synchronous active-high reset
// - start        frame request, sampled only when idle
// - lsp_idx_in   packed indices, LSB-first (4x7, 3, 3, 2 bits)
// - busy         high from the accepted start through the done cycle
// - cb_sel       codebook request to lsp_cb_rom
// - cb_addr      entry address to lsp_cb_rom
// - cb_data      entry returned by lsp_cb_rom in the same cycle
// - lsp_out      LSP in radians, Q15.16
// - lsp_num      LSP number of lsp_out
// - lsp_valid    lsp_out/lsp_num valid
// - lsp_ready    consumer ready
// - done         one-cycle pulse after LSP 9 is accepted
module lsp_dequant_2400
    import codec2_lsp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] lsp_idx_in,
    output logic             busy,
    output logic [3:0]       cb_sel,
    output logic [3:0]       cb_addr,
    input  logic [N-1:0]     cb_data,
    output logic [N-1:0]     lsp_out,
    output logic [3:0]       lsp_num,
    output logic             lsp_valid,
    input  logic             lsp_ready,
    output logic             done
);

    state_t           state;
    logic [IDX_W-1:0] idx_reg;
    logic [3:0]       k;
    logic [N-1:0]     hz_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx_reg   <= '0;
            k         <= '0;
            hz_reg    <= '0;
            busy      <= 1'b0;
            cb_sel    <= '0;
            cb_addr   <= '0;
            lsp_out   <= '0;
            lsp_num   <= '0;
            lsp_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx_reg <= lsp_idx_in;
                        k       <= '0;
                        busy    <= 1'b1;
                        // The ROM request is registered one cycle early,
                        // so cb_data is already settled during FETCH.
                        cb_sel  <= '0;
                        cb_addr <= lsp_index(lsp_idx_in, 4'd0);
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    hz_reg <= cb_data;
                    state  <= S_MUL;
                end
                S_MUL: begin
                    // Round to nearest and keep the upper 32 bits, which
                    // leaves Q15.16 radians.
                    lsp_out   <= 32'((64'(hz_reg) * 64'(C_PI4000) + 64'h0000_0000_8000_0000) >> 32);
                    lsp_num   <= k;
                    lsp_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (lsp_ready) begin
                        lsp_valid <= 1'b0;
                        if (k == 4'(NUM_LSP - 1)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            k       <= k + 4'd1;
                            cb_sel  <= k + 4'd1;
                            cb_addr <= lsp_index(idx_reg, k + 4'd1);
                            state   <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsp_dequant_2400.sv
module tb_lsp_dequant_2400;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [35:0] lsp_idx_in;
    logic        busy;
    logic [3:0]  cb_sel;
    logic [3:0]  cb_addr;
    logic [31:0] cb_data;
    logic [31:0] lsp_out;
    logic [3:0]  lsp_num;
    logic        lsp_valid;
    logic        lsp_ready;
    logic        done;

    int checks = 0;
    int errors = 0;
    int pending_done = 0;

    typedef struct {
        logic [3:0]  num;
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];

    localparam int TB_BITS [10] = '{4, 4, 4, 4, 4, 4, 4, 3, 3, 2};
    localparam int TB_BASE [10] = '{225, 325, 500, 950, 1150, 1300, 1500, 2300, 2500, 2900};
    localparam int TB_STEP [10] = '{25, 25, 50, 100, 100, 100, 100, 100, 100, 200};
    localparam int MAX_ADDR [10] = '{15, 15, 15, 15, 15, 15, 15, 7, 7, 3};

    lsp_dequant_2400 dut (
        .clk(clk), .rst(rst), .start(start), .lsp_idx_in(lsp_idx_in), .busy(busy),
        .cb_sel(cb_sel), .cb_addr(cb_addr), .cb_data(cb_data), .lsp_out(lsp_out),
        .lsp_num(lsp_num), .lsp_valid(lsp_valid), .lsp_ready(lsp_ready), .done(done)
    );

    lsp_cb_rom rom (
        .cb_sel(cb_sel), .cb_addr(cb_addr), .cb_data(cb_data)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [35:0] w, input int k);
        int          off;
        int          idx;
        logic [63:0] q;
        logic [63:0] r;
        off = 0;
        for (int i = 0; i < k; i++) off += TB_BITS[i];
        idx = int'((w >> off) & ((36'd1 << TB_BITS[k]) - 36'd1));
        q = 64'(TB_BASE[k] + TB_STEP[k] * idx) << 16;
        r = (q * 64'd3373259 + 64'h8000_0000) >> 32;
        return r[31:0];
    endfunction

    // A hand-computed value can replace the model's value for one LSP.
    task automatic push_frame(input logic [35:0] w, input int ovr_k, input logic [31:0] ovr_v);
        exp_t e;
        for (int k = 0; k < 10; k++) begin
            e.num = 4'(k);
            e.val = (k == ovr_k) ? ovr_v : model(w, k);
            sbq.push_back(e);
        end
        pending_done++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [35:0] w);
        lsp_idx_in = w;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame(input int ready_pct, input int stall_len, input bit scramble);
        int stall_cnt;
        bit finished;
        stall_cnt = 0;
        finished = 1'b0;
        for (int t = 0; t < 2000 && !finished; t++) begin
            if (stall_len > 0 && lsp_valid && lsp_num == 4'd4 && stall_cnt < stall_len) begin
                lsp_ready = 1'b0;
                stall_cnt++;
            end else begin
                lsp_ready = ($urandom_range(99) < 32'(ready_pct));
            end
            if (scramble) begin
                lsp_idx_in = {4'($urandom), $urandom};
                start = ($urandom_range(3) == 0);
            end
            tick();
            if (pending_done == 0 && sbq.size() == 0) finished = 1'b1;
        end
        start = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got pending=%0d expected 0", sbq.size());
        end
    endtask

    // Monitor: handshake and done are sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (lsp_valid && lsp_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_lsp: got num=%0d out=0x%0h expected none", lsp_num, lsp_out);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("lsp_num", 64'(lsp_num), 64'(e.num));
                    chk("lsp_out", 64'(lsp_out), 64'(e.val));
                end
            end
            if (done) begin
                chk("done_expected", 64'(pending_done > 0), 64'd1);
                chk("done_after_last_lsp", 64'(sbq.size()), 64'd0);
                if (pending_done > 0) pending_done--;
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(lsp_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_lsp_out", 64'(lsp_out), 64'd0);
        chk("rst_lsp_num", 64'(lsp_num), 64'd0);
        chk("rst_cb_sel", 64'(cb_sel), 64'd0);
        chk("rst_cb_addr", 64'(cb_addr), 64'd0);
    endtask

    initial begin
        logic [35:0] wa;
        logic [35:0] wb;
        int first_valid;
        int done_cyc;
        int done_cnt;

        rst = 1'b1;
        start = 1'b0;
        lsp_idx_in = '0;
        lsp_ready = 1'b0;
        tick();
        tick();
        chk_reset_outputs();
        rst = 1'b0;
        tick();

        // All-zero word: latency and hand-computed LSP3 (950 Hz -> 0xBF02).
        push_frame(36'h0, 3, 32'h0000_BF02);
        lsp_ready = 1'b1;
        pulse_start(36'h0);
        first_valid = -1;
        done_cyc = -1;
        done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (lsp_valid && first_valid < 0) first_valid = c;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            tick();
        end
        chk("first_valid_cycle", 64'(first_valid), 64'd3);
        chk("done_cycle", 64'(done_cyc), 64'd31);
        chk("done_count_zero_word", 64'(done_cnt), 64'd1);
        chk("zero_frame_drained", 64'(sbq.size()), 64'd0);

        // Max indices: ROM addresses and hand-computed LSP3 (2450 Hz -> 0x1EC9A).
        push_frame(36'hF_FFFF_FFFF, 3, 32'h0001_EC9A);
        pulse_start(36'hF_FFFF_FFFF);
        for (int c = 1; c <= 40; c++) begin
            if ((c - 1) % 3 == 0 && (c - 1) / 3 < 10) begin
                chk("max_cb_sel", 64'(cb_sel), 64'((c - 1) / 3));
                chk("max_cb_addr", 64'(cb_addr), 64'(MAX_ADDR[(c - 1) / 3]));
            end
            tick();
        end
        chk("max_frame_drained", 64'(sbq.size()), 64'd0);

        // Backpressure: ready low 7 cycles while LSP 4 is presented.
        wa = 36'h5_A3C6_9E17;
        push_frame(wa, -1, '0);
        pulse_start(wa);
        wait_frame(100, 7, 1'b0);

        // Start while busy, index word changed mid-frame, and start coincident with done.
        wa = 36'h9_3C5A_7E12;
        wb = ~wa;
        push_frame(wa, -1, '0);
        lsp_ready = 1'b1;
        pulse_start(wa);
        for (int c = 1; c <= 40; c++) begin
            if (c == 5 || c == 17 || c == 31) begin
                lsp_idx_in = wb;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (c == 31) chk("done_coincident_start", 64'(done), 64'd1);
            if (c == 32 || c == 33) chk("idle_after_done", 64'(busy), 64'd0);
            tick();
        end
        start = 1'b0;
        chk("ignore_frame_drained", 64'(sbq.size()), 64'd0);

        // Reset mid-frame: abort, no done, then a full frame runs.
        wa = 36'h3_1415_9265;
        push_frame(wa, -1, '0);
        pulse_start(wa);
        for (int c = 1; c <= 10; c++) tick();
        lsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk_reset_outputs();
        tick();
        chk_reset_outputs();
        sbq.delete();
        pending_done = 0;
        rst = 1'b0;
        lsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("no_done_after_abort", 64'(done), 64'd0);
            tick();
        end
        wb = 36'hA_BCDE_F012;
        push_frame(wb, -1, '0);
        pulse_start(wb);
        wait_frame(100, 0, 1'b0);

        // Random words, random ready, input noise while busy.
        for (int f = 0; f < 1000; f++) begin
            wa = {4'($urandom), $urandom};
            push_frame(wa, -1, '0);
            pulse_start(wa);
            wait_frame(75, 0, 1'b1);
            lsp_ready = 1'b0;
            tick();
            tick();
        end
        chk("final_pending_done", 64'(pending_done), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
